// File: rtl/chien_pkg.sv
`default_nettype none
// chien_pkg: shared state encoding, command-bus bit positions and GF(2^9) alpha constants.
package chien_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD_LO = 3'd1,
      LOAD_HI = 3'd2,
      CALC    = 3'd3,
      WAIT    = 3'd4,
      GAP     = 3'd5,
      EMIT    = 3'd6,
      FIN     = 3'd7
   } state_t;

   localparam int c_bit_wr_lo = 31;
   localparam int c_bit_wr_hi = 30;
   localparam int c_bit_calc  = 28;
   localparam int c_odd_lsb   = 16;

   // alpha^1..alpha^4 in GF(2^9) with x^9 + x^4 + 1; below x^9 no reduction happens
   localparam logic [8:0] c_alpha1 = 9'h002;
   localparam logic [8:0] c_alpha2 = 9'h004;
   localparam logic [8:0] c_alpha3 = 9'h008;
   localparam logic [8:0] c_alpha4 = 9'h010;

endpackage
`default_nettype wire

// File: rtl/chien_root_fifo.sv
`default_nettype none
// chien_root_fifo: queue of root positions; a push into a full queue is taken when a pop
// happens in the same cycle.
module chien_root_fifo #(
   parameter int PARAM_M     = 9,
   parameter int PARAM_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_push,
   input  logic [PARAM_M-1:0] i_data,
   input  logic               i_pop,
   output logic               o_valid,
   output logic               o_full,
   output logic [PARAM_M-1:0] o_data
);

   localparam int c_aw = $clog2(PARAM_DEPTH);

   logic [PARAM_M-1:0] r_mem [PARAM_DEPTH];
   logic [c_aw:0]      r_wr;
   logic [c_aw:0]      r_rd;
   logic               w_empty;
   logic               w_full;
   logic               w_do_pop;
   logic               w_do_push;

   assign w_empty   = (r_wr == r_rd);
   assign w_full    = (r_wr[c_aw] != r_rd[c_aw]) && (r_wr[c_aw-1:0] == r_rd[c_aw-1:0]);
   assign w_do_pop  = i_pop && !w_empty;
   assign w_do_push = i_push && (!w_full || w_do_pop);

   assign o_valid = !w_empty;
   assign o_full  = w_full;
   assign o_data  = r_mem[r_rd[c_aw-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_do_push) r_wr <= r_wr + (c_aw+1)'(1);
         if (w_do_pop)  r_rd <= r_rd + (c_aw+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr[c_aw-1:0]] <= i_data;
   end

endmodule
`default_nettype wire

// File: rtl/chien_sched.sv
`default_nettype none
// chien_sched: sequences an external 4-lane Chien unit over j = 1..n_points and queues the
// positions j where sigma(alpha^j) == 0.
module chien_sched
   import chien_pkg::*;
#(
   parameter int PARAM_M     = 9,
   parameter int PARAM_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [PARAM_M-1:0] n_points,
   input  logic [2:0]         deg,
   input  logic               coef_we,
   input  logic [2:0]         coef_addr,
   input  logic [PARAM_M-1:0] coef_data,
   output logic               busy,
   output logic               done,
   output logic               fail,
   output logic [PARAM_M-1:0] root_cnt,
   output logic               root_valid,
   output logic [PARAM_M-1:0] root_pos,
   input  logic               root_ready,
   output logic               ch_enable,
   output logic [31:0]        ch_in_1,
   output logic [31:0]        ch_in_2,
   input  logic [31:0]        ch_out_1,
   input  logic               ch_ready
);

   localparam logic [PARAM_M-1:0] c_a1     = PARAM_M'(c_alpha1);
   localparam logic [PARAM_M-1:0] c_a2     = PARAM_M'(c_alpha2);
   localparam logic [PARAM_M-1:0] c_a3     = PARAM_M'(c_alpha3);
   localparam logic [PARAM_M-1:0] c_a4     = PARAM_M'(c_alpha4);
   localparam logic [31:0]        c_cmd_lo = 32'd1 << c_bit_wr_lo;
   localparam logic [31:0]        c_cmd_hi = 32'd1 << c_bit_wr_hi;
   localparam logic [31:0]        c_cmd_cl = 32'd1 << c_bit_calc;

   state_t             r_state;
   logic               r_ph;
   logic               r_seen_low;
   logic [PARAM_M-1:0] r_sigma [5];
   logic [PARAM_M-1:0] r_j;
   logic [PARAM_M-1:0] r_n;
   logic [PARAM_M-1:0] r_s;
   logic [PARAM_M-1:0] r_root_cnt;
   logic [2:0]         r_deg;
   logic               r_busy;
   logic               r_done;
   logic               r_fail;
   logic               r_en;
   logic [31:0]        r_in1;
   logic [31:0]        r_in2;

   logic [2:0]         w_deg;
   logic [PARAM_M-1:0] w_lsig [4];
   logic               w_full;
   logic               w_pop;
   logic               w_can_push;
   logic               w_push;
   logic               w_unused_ok;

   function automatic logic [31:0] f_pack(input logic [PARAM_M-1:0] ev,
                                          input logic [PARAM_M-1:0] od);
      logic [31:0] v;
      v = '0;
      v[PARAM_M-1:0]           = ev;
      v[c_odd_lsb +: PARAM_M]  = od;
      return v;
   endfunction

   // The first lane pair is issued on the start edge, before r_deg holds the new degree
   assign w_deg = (r_state == IDLE) ? deg : r_deg;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_lsig[i] = (32'(w_deg) > i) ? r_sigma[i+1] : '0;
      end
   end

   assign w_pop       = root_valid && root_ready;
   assign w_can_push  = !w_full || w_pop;
   assign w_push      = (r_state == EMIT) && (r_s == '0) && w_can_push;
   assign w_unused_ok = ^ch_out_1[31:PARAM_M];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 5; i++) r_sigma[i] <= '0;
      end else if (coef_we && (r_state == IDLE) && (coef_addr <= 3'd4)) begin
         r_sigma[coef_addr] <= coef_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_ph       <= 1'b0;
         r_seen_low <= 1'b0;
         r_j        <= '0;
         r_n        <= '0;
         r_s        <= '0;
         r_root_cnt <= '0;
         r_deg      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_fail     <= 1'b0;
         r_en       <= 1'b0;
         r_in1      <= '0;
         r_in2      <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_root_cnt <= '0;
                  r_fail     <= 1'b0;
                  r_deg      <= deg;
                  r_n        <= n_points;
                  r_j        <= PARAM_M'(1);
                  r_busy     <= 1'b1;
                  if (n_points == '0) begin
                     r_state <= FIN;
                  end else begin
                     r_state <= LOAD_LO;
                     r_ph    <= 1'b0;
                     r_en    <= 1'b1;
                     r_in1   <= f_pack(w_lsig[0], w_lsig[1]);
                     r_in2   <= f_pack(c_a1, c_a2) | c_cmd_lo;
                  end
               end
            end
            LOAD_LO: begin
               if (!r_ph) begin
                  r_ph  <= 1'b1;
                  r_en  <= 1'b0;
                  r_in1 <= '0;
                  r_in2 <= '0;
               end else begin
                  r_state <= LOAD_HI;
                  r_ph    <= 1'b0;
                  r_en    <= 1'b1;
                  r_in1   <= f_pack(w_lsig[2], w_lsig[3]);
                  r_in2   <= f_pack(c_a3, c_a4) | c_cmd_hi;
               end
            end
            LOAD_HI: begin
               if (!r_ph) begin
                  r_ph  <= 1'b1;
                  r_en  <= 1'b0;
                  r_in1 <= '0;
                  r_in2 <= '0;
               end else begin
                  r_state <= CALC;
                  r_ph    <= 1'b0;
                  r_en    <= 1'b1;
                  r_in1   <= '0;
                  r_in2   <= c_cmd_cl;
               end
            end
            CALC: begin
               r_state    <= WAIT;
               r_seen_low <= 1'b0;
            end
            WAIT: begin
               // ready may still be high from a stale result; only a low-to-high edge counts
               if (!ch_ready) begin
                  r_seen_low <= 1'b1;
               end else if (r_seen_low) begin
                  r_s     <= ch_out_1[PARAM_M-1:0] ^ r_sigma[0];
                  r_en    <= 1'b0;
                  r_in2   <= '0;
                  r_state <= GAP;
               end
            end
            GAP: begin
               r_state <= EMIT;
            end
            EMIT: begin
               if ((r_s != '0) || w_can_push) begin
                  if ((r_s == '0) && (r_root_cnt != '1)) r_root_cnt <= r_root_cnt + PARAM_M'(1);
                  if (r_j == r_n) begin
                     r_state <= FIN;
                  end else begin
                     r_j     <= r_j + PARAM_M'(1);
                     r_state <= CALC;
                     r_en    <= 1'b1;
                     r_in2   <= c_cmd_cl;
                  end
               end
            end
            FIN: begin
               r_done  <= 1'b1;
               r_fail  <= (r_root_cnt != PARAM_M'(r_deg));
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   chien_root_fifo #(
      .PARAM_M     (PARAM_M),
      .PARAM_DEPTH (PARAM_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (r_j),
      .i_pop   (root_ready),
      .o_valid (root_valid),
      .o_full  (w_full),
      .o_data  (root_pos)
   );

   assign busy      = r_busy;
   assign done      = r_done;
   assign fail      = r_fail;
   assign root_cnt  = r_root_cnt;
   assign ch_enable = r_en;
   assign ch_in_1   = r_in1;
   assign ch_in_2   = r_in2;

endmodule
`default_nettype wire

// File: tb/tb_chien_sched.sv
`default_nettype none
// tb_chien_sched: directed bench with a behavioural 4-lane Chien unit and GF(2^9) reference.
module tb_chien_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [8:0]  n_points = '0;
   logic [2:0]  deg = '0;
   logic        coef_we = 1'b0;
   logic [2:0]  coef_addr = '0;
   logic [8:0]  coef_data = '0;
   logic        busy, done, fail, root_valid, ch_enable, ch_ready;
   logic [8:0]  root_cnt, root_pos;
   logic        root_ready = 1'b0;
   logic [31:0] ch_in_1, ch_in_2, ch_out_1;

   int n_checks = 0;
   int n_fail   = 0;
   int calc_cnt = 0;
   int en_cnt   = 0;
   int done_cnt = 0;
   logic [8:0] pq[$];
   logic [8:0] p [5];

   always #5 clk = ~clk;

   chien_sched #(.PARAM_M(9), .PARAM_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .start(start), .n_points(n_points), .deg(deg),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .busy(busy), .done(done), .fail(fail), .root_cnt(root_cnt),
      .root_valid(root_valid), .root_pos(root_pos), .root_ready(root_ready),
      .ch_enable(ch_enable), .ch_in_1(ch_in_1), .ch_in_2(ch_in_2),
      .ch_out_1(ch_out_1), .ch_ready(ch_ready)
   );

   function automatic logic [8:0] gf_mul(input logic [8:0] a, input logic [8:0] b);
      logic [8:0] r, x;
      logic       hi;
      r = '0; x = a;
      for (int i = 0; i < 9; i++) begin
         if (b[i]) r = r ^ x;
         hi = x[8];
         x  = {x[7:0], 1'b0};
         if (hi) x = x ^ 9'h011;
      end
      return r;
   endfunction

   function automatic logic [8:0] gf_pow(input int e);
      logic [8:0] r;
      r = 9'h001;
      for (int k = 0; k < (e % 511); k++) r = gf_mul(r, 9'h002);
      return r;
   endfunction

   // Behavioural Chien unit: result two cycles after a calc request, locked until enable drops
   logic [8:0]  m_sig [4];
   logic [8:0]  m_alp [4];
   logic [8:0]  ld_sig [4];
   logic        m_lock;
   int          m_cnt;
   always @(posedge clk or negedge rst) begin
      logic [8:0] acc, t;
      if (!rst) begin
         ch_ready <= 1'b0; m_lock <= 1'b0; m_cnt <= 0; ch_out_1 <= '0;
      end else if (!ch_enable) begin
         ch_ready <= 1'b0; m_lock <= 1'b0; m_cnt <= 0;
      end else if (ch_in_2[31] || ch_in_2[30]) begin
         for (int l = 0; l < 2; l++) begin
            m_sig [(ch_in_2[31] ? 0 : 2) + l] <= ch_in_1[16*l +: 9];
            ld_sig[(ch_in_2[31] ? 0 : 2) + l] <= ch_in_1[16*l +: 9];
            m_alp [(ch_in_2[31] ? 0 : 2) + l] <= ch_in_2[16*l +: 9];
         end
      end else if (ch_in_2[28] && !m_lock) begin
         if (m_cnt == 2) begin
            acc = '0;
            for (int l = 0; l < 4; l++) begin
               t = gf_mul(m_sig[l], m_alp[l]);
               m_sig[l] <= t;
               acc = acc ^ t;
            end
            ch_out_1 <= {23'h0, acc};
            ch_ready <= 1'b1; m_lock <= 1'b1; m_cnt <= 0;
            calc_cnt++;
         end else begin
            m_cnt <= m_cnt + 1;
         end
      end
   end

   always @(negedge clk) begin
      #1;
      if (ch_enable) en_cnt++;
      if (done) done_cnt++;
      if (root_valid && root_ready) pq.push_back(root_pos);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int a, input logic [8:0] d);
      @(negedge clk); coef_we = 1'b1; coef_addr = 3'(a); coef_data = d;
      @(negedge clk); coef_we = 1'b0;
   endtask

   task automatic load_p();
      for (int i = 0; i < 5; i++) wr(i, p[i]);
   endtask

   task automatic pinit();
      p[0] = 9'h001;
      for (int i = 1; i < 5; i++) p[i] = '0;
   endtask

   task automatic pmul_root(input int j);
      logic [8:0] r;
      r = gf_pow(511 - j);
      for (int i = 4; i >= 1; i--) p[i] = p[i] ^ gf_mul(p[i-1], r);
   endtask

   task automatic start_search(input int n, input int dg);
      @(negedge clk); n_points = 9'(n); deg = 3'(dg); start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("busy_after_start", busy, 1);
   endtask

   task automatic wait_done(input string tag);
      bit ok;
      ok = 0;
      for (int i = 0; i < 3000; i++) begin
         if (done) begin ok = 1; break; end
         @(negedge clk);
      end
      check(tag, ok, 1);
      @(negedge clk);
      check({tag, "_pulse"}, done, 0);
   endtask

   task automatic wait_en(input logic lvl, input string tag);
      bit ok;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         if (ch_enable === lvl) begin ok = 1; break; end
         @(negedge clk);
      end
      check(tag, ok, 1);
   endtask

   initial begin
      int  base, ebase, dbase;
      bit  ok;

      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_fail", fail, 0);
      check("rst_root_cnt", root_cnt, 0);
      check("rst_root_valid", root_valid, 0);
      check("rst_ch_enable", ch_enable, 0);
      check("rst_ch_in_1", ch_in_1, 0);
      check("rst_ch_in_2", ch_in_2, 0);
      rst = 1'b1;

      // deg 0, sigma = 1: no roots
      root_ready = 1'b1;
      pinit(); load_p();
      base = calc_cnt; pq.delete();
      start_search(10, 0);
      wait_done("a_done");
      check("a_calcs", calc_cnt - base, 10);
      check("a_root_cnt", root_cnt, 0);
      check("a_fail", fail, 0);
      check("a_pops", pq.size(), 0);

      // deg 1, root at 5; sigma2 loaded but above degree; writes and start while busy ignored
      p[0] = 9'h001; p[1] = gf_pow(506); p[2] = 9'h055; p[3] = '0; p[4] = '0;
      load_p();
      base = calc_cnt; pq.delete();
      start_search(10, 1);
      repeat (30) @(negedge clk);
      wr(0, 9'h1FF);
      n_points = 9'd3; start = 1'b1; @(negedge clk); start = 1'b0;
      wait_done("b_done");
      check("b_calcs", calc_cnt - base, 10);
      check("b_root_cnt", root_cnt, 1);
      check("b_fail", fail, 0);
      check("b_pops", pq.size(), 1);
      if (pq.size() > 0) check("b_pos", pq[0], 5);
      check("b_lane0_sig", ld_sig[0], gf_pow(506));
      check("b_lane1_sig", ld_sig[1], 0);
      for (int l = 0; l < 4; l++) check("b_lane_alpha", m_alp[l], gf_pow(l + 1));

      // deg 2, roots 3 and 7 queued with no consumer
      root_ready = 1'b0;
      pinit(); pmul_root(3); pmul_root(7); load_p();
      start_search(10, 2);
      wait_done("c_done");
      check("c_root_cnt", root_cnt, 2);
      check("c_fail", fail, 0);
      check("c_valid", root_valid, 1);
      check("c_pos0", root_pos, 3);
      root_ready = 1'b1; @(negedge clk); root_ready = 1'b0;
      check("c_pos1", root_pos, 7);
      root_ready = 1'b1; @(negedge clk); root_ready = 1'b0;
      check("c_empty", root_valid, 0);

      // deg 3 with third root outside range; entries 2,6 stay queued
      pinit(); pmul_root(2); pmul_root(6); pmul_root(20); load_p();
      start_search(10, 3);
      wait_done("d_done");
      check("d_root_cnt", root_cnt, 2);
      check("d_fail", fail, 1);
      check("d_pos", root_pos, 2);

      // deg 4, roots 1..4 behind two leftover entries: stalls on full, then drains
      pinit(); pmul_root(1); pmul_root(2); pmul_root(3); pmul_root(4); load_p();
      dbase = done_cnt; pq.delete();
      start_search(6, 4);
      repeat (200) @(negedge clk);
      check("e_stall_busy", busy, 1);
      check("e_stall_nodone", done_cnt - dbase, 0);
      check("e_stall_cnt", root_cnt, 2);
      root_ready = 1'b1;
      wait_done("e_done");
      check("e_root_cnt", root_cnt, 4);
      check("e_fail", fail, 0);
      check("e_pops", pq.size(), 6);
      if (pq.size() == 6) begin
         check("e_p0", pq[0], 2); check("e_p1", pq[1], 6); check("e_p2", pq[2], 1);
         check("e_p3", pq[3], 2); check("e_p4", pq[4], 3); check("e_p5", pq[5], 4);
      end

      // reset during WAIT of j=4
      pinit(); load_p();
      base = calc_cnt;
      start_search(10, 0);
      ok = 0;
      for (int i = 0; i < 500; i++) begin
         if (calc_cnt - base >= 3) begin ok = 1; break; end
         @(negedge clk);
      end
      check("f_reach_j3", ok, 1);
      wait_en(1'b0, "f_gap");
      wait_en(1'b1, "f_calc4");
      @(negedge clk);
      #2 rst = 1'b0; dbase = done_cnt;
      #1;
      check("f_calcs", calc_cnt - base, 3);
      check("f_busy", busy, 0);
      check("f_done", done, 0);
      check("f_fail", fail, 0);
      check("f_root_cnt", root_cnt, 0);
      check("f_root_valid", root_valid, 0);
      check("f_ch_enable", ch_enable, 0);
      check("f_ch_in_1", ch_in_1, 0);
      check("f_ch_in_2", ch_in_2, 0);
      @(negedge clk);
      check("f_no_done", done_cnt - dbase, 0);
      rst = 1'b1;
      // sigma was cleared, so every point is a root
      base = calc_cnt; pq.delete();
      start_search(5, 0);
      wait_done("f2_done");
      check("f2_calcs", calc_cnt - base, 5);
      check("f2_root_cnt", root_cnt, 5);
      check("f2_fail", fail, 1);
      check("f2_pops", pq.size(), 5);
      if (pq.size() == 5) for (int i = 0; i < 5; i++) check("f2_pos", pq[i], i + 1);

      // n_points = 0
      ebase = en_cnt;
      start_search(0, 0);
      check("g_done_early", done, 0);
      @(negedge clk);
      check("g_done", done, 1);
      check("g_root_cnt", root_cnt, 0);
      check("g_busy", busy, 0);
      check("g_no_enable", en_cnt - ebase, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
